// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: waits for the init engine, then grants the bus to refresh, write or read.
// Optional grant watchdog is enabled by defining SDRAM_ARB_WDOG_EN.
module sdram_arbiter #(
    parameter logic [3:0] NOP_CMD = 4'b0111
`ifdef SDRAM_ARB_WDOG_EN
    ,
    parameter int WDOG_CYCLES = 1023
`endif
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [11:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [11:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [11:0] wr_addr,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [11:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [11:0] sdram_addr,
    output logic        arb_busy,
    output logic        wdog_err
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t state_reg;
    logic   aref_en_reg;
    logic   wr_en_reg;
    logic   rd_en_reg;
    logic   last_wr_reg;
    logic   in_burst;
    logic   end_hit;
    logic   wdog_fire;

    assign in_burst = (state_reg == ST_AREF) || (state_reg == ST_WRITE) || (state_reg == ST_READ);

    // Only the end pulse of the engine currently holding the bus counts.
    assign end_hit = ((state_reg == ST_AREF)  && aref_end) ||
                     ((state_reg == ST_WRITE) && wr_end)   ||
                     ((state_reg == ST_READ)  && rd_end);

`ifdef SDRAM_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_reg;
    logic              wdog_err_reg;

    // Counter sits at zero outside a grant, so every grant entry starts from a clean count.
    assign wdog_fire = in_burst && !end_hit && (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wdog_cnt_reg <= '0;
            wdog_err_reg <= 1'b0;
        end else begin
            if (in_burst && !end_hit && !wdog_fire) begin
                wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
            end else begin
                wdog_cnt_reg <= '0;
            end
            if (wdog_fire) begin
                wdog_err_reg <= 1'b1;
            end
        end
    end

    assign wdog_err = wdog_err_reg;
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= ST_INIT;
            aref_en_reg <= 1'b0;
            wr_en_reg   <= 1'b0;
            rd_en_reg   <= 1'b0;
            last_wr_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (init_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (aref_req) begin
                        state_reg   <= ST_AREF;
                        aref_en_reg <= 1'b1;
                    end else if (wr_req && (!rd_req || !last_wr_reg)) begin
                        state_reg   <= ST_WRITE;
                        wr_en_reg   <= 1'b1;
                        last_wr_reg <= 1'b1;
                    end else if (rd_req) begin
                        state_reg   <= ST_READ;
                        rd_en_reg   <= 1'b1;
                        last_wr_reg <= 1'b0;
                    end
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    // Returning through IDLE guarantees one NOP cycle between grants.
                    if (end_hit || wdog_fire) begin
                        state_reg   <= ST_IDLE;
                        aref_en_reg <= 1'b0;
                        wr_en_reg   <= 1'b0;
                        rd_en_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ST_INIT;
                    aref_en_reg <= 1'b0;
                    wr_en_reg   <= 1'b0;
                    rd_en_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign aref_en  = aref_en_reg;
    assign wr_en    = wr_en_reg;
    assign rd_en    = rd_en_reg;
    assign arb_busy = (state_reg != ST_IDLE);

    always_comb begin
        sdram_cmd  = NOP_CMD;
        sdram_ba   = 2'd0;
        sdram_addr = 12'd0;
        case (state_reg)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                sdram_cmd  = NOP_CMD;
                sdram_ba   = 2'd0;
                sdram_addr = 12'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: init hand-off, priority, round-robin, end filtering, async reset.
module tb_sdram_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_done;
    logic [3:0]  init_cmd = 4'h1;
    logic [1:0]  init_ba = 2'd1;
    logic [11:0] init_addr = 12'h111;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd = 4'h2;
    logic [1:0]  aref_ba = 2'd2;
    logic [11:0] aref_addr = 12'h222;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd = 4'h4;
    logic [1:0]  wr_ba = 2'd3;
    logic [11:0] wr_addr = 12'h444;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd = 4'h8;
    logic [1:0]  rd_ba = 2'd0;
    logic [11:0] rd_addr = 12'h888;
    logic        aref_en, wr_en, rd_en;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic        arb_busy, wdog_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam int SEL_INIT = 0, SEL_NOP = 1, SEL_AREF = 2, SEL_WR = 3, SEL_RD = 4;

    always #5 sys_clk = ~sys_clk;

    sdram_arbiter #(
        .NOP_CMD(4'b0111)
`ifdef SDRAM_ARB_WDOG_EN
        ,
        .WDOG_CYCLES(16)
`endif
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end),
        .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_end(rd_end),
        .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .arb_busy(arb_busy), .wdog_err(wdog_err)
    );

    function automatic logic [17:0] exp_bus(input int sel);
        case (sel)
            SEL_INIT: return {4'h1, 2'd1, 12'h111};
            SEL_AREF: return {4'h2, 2'd2, 12'h222};
            SEL_WR:   return {4'h4, 2'd3, 12'h444};
            SEL_RD:   return {4'h8, 2'd0, 12'h888};
            default:  return {4'b0111, 2'd0, 12'h000};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks grants, bus contents, busy flag and watchdog flag together.
    task automatic chk_all(input string tag, input logic [2:0] gnt, input int sel, input logic err);
        chk({tag, "_gnt"}, {29'd0, aref_en, wr_en, rd_en}, {29'd0, gnt});
        chk({tag, "_bus"}, {14'd0, sdram_cmd, sdram_ba, sdram_addr}, {14'd0, exp_bus(sel)});
        chk({tag, "_busy"}, {31'd0, arb_busy}, {31'd0, (sel != SEL_NOP)});
        chk({tag, "_wdog"}, {31'd0, wdog_err}, {31'd0, err});
        $display("step %-12s t=%0t gnt=%b%b%b cmd=%h busy=%b", tag, $time, aref_en, wr_en, rd_en,
                 sdram_cmd, arb_busy);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        init_done = 1'b0;
        aref_req = 1'b0; aref_end = 1'b0;
        wr_req = 1'b0; wr_end = 1'b0;
        rd_req = 1'b0; rd_end = 1'b0;
        #1;
        chk_all("reset", 3'b000, SEL_INIT, 1'b0);

        // Test 1: init hand-off with a write already pending.
        step(); step();
        sys_rst_n = 1'b1;
        wr_req = 1'b1;
        for (int c = 1; c < 20; c++) begin
            step();
            if (c % 6 == 0) chk_all("init_wait", 3'b000, SEL_INIT, 1'b0);
        end
        init_done = 1'b1;
        step();
        chk_all("t1_idle", 3'b000, SEL_NOP, 1'b0);
        step();
        chk_all("t1_wr", 3'b010, SEL_WR, 1'b0);
        wr_req = 1'b0;
        step();
        chk_all("t1_wr_hold", 3'b010, SEL_WR, 1'b0);
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_all("t1_end", 3'b000, SEL_NOP, 1'b0);

        // Read-only burst: also clears the round-robin bit.
        rd_req = 1'b1;
        step();
        chk_all("rd_only", 3'b001, SEL_RD, 1'b0);
        rd_req = 1'b0;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk_all("rd_only_end", 3'b000, SEL_NOP, 1'b0);

        // A request dropped while still idle is not remembered.
        wr_req = 1'b1;
        #1 wr_req = 1'b0;
        step();
        chk_all("drop_req", 3'b000, SEL_NOP, 1'b0);

        // Test 2: all three requests together.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        step();
        chk_all("t2_aref", 3'b100, SEL_AREF, 1'b0);
        step();
        chk_all("t2_aref_hold", 3'b100, SEL_AREF, 1'b0);
        aref_end = 1'b1; aref_req = 1'b0;
        step();
        aref_end = 1'b0;
        chk_all("t2_gap1", 3'b000, SEL_NOP, 1'b0);
        step();
        chk_all("t2_wr", 3'b010, SEL_WR, 1'b0);
        wr_end = 1'b1; wr_req = 1'b0;
        step();
        wr_end = 1'b0;
        chk_all("t2_gap2", 3'b000, SEL_NOP, 1'b0);
        step();
        chk_all("t2_rd", 3'b001, SEL_RD, 1'b0);
        rd_end = 1'b1; rd_req = 1'b0;
        step();
        rd_end = 1'b0;
        chk_all("t2_gap3", 3'b000, SEL_NOP, 1'b0);

        // Test 4: continuous write and read requests alternate W,R,W,R,W,R.
        wr_req = 1'b1; rd_req = 1'b1;
        for (int b = 0; b < 6; b++) begin
            step();
            if (b % 2 == 0) chk_all("t4_burst_w", 3'b010, SEL_WR, 1'b0);
            else            chk_all("t4_burst_r", 3'b001, SEL_RD, 1'b0);
            step();
            if (b % 2 == 0) begin
                wr_end = 1'b1;
            end else begin
                rd_end = 1'b1;
            end
            if (b == 5) begin
                wr_req = 1'b0; rd_req = 1'b0;
            end
            step();
            wr_end = 1'b0; rd_end = 1'b0;
            chk_all("t4_gap", 3'b000, SEL_NOP, 1'b0);
        end

        // Test 3: refresh raised mid-write waits for the write to finish.
        wr_req = 1'b1;
        for (int g = 1; g <= 12; g++) begin
            step();
            chk_all("t3_wr", 3'b010, SEL_WR, 1'b0);
            wr_req = 1'b0;
            if (g == 3) aref_req = 1'b1;
            if (g == 12) wr_end = 1'b1;
        end
        step();
        wr_end = 1'b0;
        chk_all("t3_gap", 3'b000, SEL_NOP, 1'b0);
        step();
        chk_all("t3_aref", 3'b100, SEL_AREF, 1'b0);
        aref_end = 1'b1; aref_req = 1'b0;
        step();
        aref_end = 1'b0;
        chk_all("t3_end", 3'b000, SEL_NOP, 1'b0);

        // Test 5: foreign end pulses are ignored, then reset mid-write.
        wr_req = 1'b1;
        step();
        chk_all("t5_wr", 3'b010, SEL_WR, 1'b0);
        wr_req = 1'b0;
        rd_end = 1'b1; aref_end = 1'b1;
        step();
        rd_end = 1'b0; aref_end = 1'b0;
        chk_all("t5_spurious", 3'b010, SEL_WR, 1'b0);
        step();
        sys_rst_n = 1'b0;
        init_done = 1'b0;
        #1;
        chk_all("t5_async_rst", 3'b000, SEL_INIT, 1'b0);
        step();
        sys_rst_n = 1'b1;
        rd_req = 1'b1;
        step();
        chk_all("t5_reinit", 3'b000, SEL_INIT, 1'b0);
        init_done = 1'b1;
        step();
        chk_all("t5_idle", 3'b000, SEL_NOP, 1'b0);
        step();
        chk_all("t5_rd", 3'b001, SEL_RD, 1'b0);
        rd_req = 1'b0;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk_all("t5_rd_end", 3'b000, SEL_NOP, 1'b0);

`ifdef SDRAM_ARB_WDOG_EN
        // Test 6: a write that never ends is cut off after 16 grant cycles.
        wr_req = 1'b1;
        for (int g = 1; g <= 16; g++) begin
            step();
            chk_all("t6_wr", 3'b010, SEL_WR, 1'b0);
            wr_req = 1'b0;
        end
        step();
        chk_all("t6_wdog", 3'b000, SEL_NOP, 1'b1);
        rd_req = 1'b1;
        step();
        chk_all("t6_rd", 3'b001, SEL_RD, 1'b1);
        rd_req = 1'b0;
        rd_end = 1'b1;
        step();
        rd_end = 1'b0;
        chk_all("t6_sticky", 3'b000, SEL_NOP, 1'b1);
`else
        // Without the watchdog a grant is held indefinitely.
        wr_req = 1'b1;
        for (int g = 1; g <= 40; g++) begin
            step();
            wr_req = 1'b0;
            if (g % 10 == 0) chk_all("long_wr", 3'b010, SEL_WR, 1'b0);
        end
        wr_end = 1'b1;
        step();
        wr_end = 1'b0;
        chk_all("long_wr_end", 3'b000, SEL_NOP, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Grant exclusivity is checked on every cycle.
    always @(negedge sys_clk) begin
        if ((32'(aref_en) + 32'(wr_en) + 32'(rd_en)) > 32'd1) begin
            n_err++;
            $display("FAIL grant_onehot observed=%b%b%b expected=at most one", aref_en, wr_en, rd_en);
        end
    end

endmodule
